// File: rtl/dff_reset_en_pkg.sv
// ----------------------------------------------------------------------------
// dff_reset_en_pkg
// Shared constants for the register primitives: the legal data-width range
// and the default reset value width helper.
// ----------------------------------------------------------------------------
package dff_reset_en_pkg;

    // Legal range for the WIDTH parameter of register primitives.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 1024;

    // True when a requested width is inside the supported range.
    function automatic bit width_ok(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/dff_reset_en.sv
// ----------------------------------------------------------------------------
// dff_reset_en
// Parameterised D register with asynchronous active-low reset and a
// synchronous active-high load enable.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous reset, active-low (q forced to RESET_VAL)
//   en     in   1      load enable; q <= d on a rising edge when high
//   d      in   WIDTH  data to capture
//   q      out  WIDTH  registered data
// ----------------------------------------------------------------------------
module dff_reset_en
    import dff_reset_en_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject unsupported widths at elaboration.
    if (!width_ok(WIDTH)) begin : g_width_check
        $fatal(1, "dff_reset_en: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    logic [WIDTH-1:0] r_q;

    // Reset is checked first so a reset edge coinciding with a clock edge wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_dff_reset_en.sv
// ----------------------------------------------------------------------------
// tb_dff_reset_en
// Self-checking bench for dff_reset_en: a default 1-bit instance and an
// 8-bit instance with RESET_VAL = 8'hA5, driven from shared clk/reset/en.
// ----------------------------------------------------------------------------
module tb_dff_reset_en;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;

    // Reference model: the value each register should currently hold.
    logic       m_q1;
    logic [7:0] m_q8;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic       RV1 = 1'b0;
    localparam logic [7:0] RV8 = 8'hA5;

    always #10 clk = ~clk;

    dff_reset_en u_dut1 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d1),
        .q     (q1)
    );

    dff_reset_en #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d8),
        .q     (q8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_w1"}, {31'd0, q1}, {31'd0, m_q1});
        check({tag, "_w8"}, {24'd0, q8}, {24'd0, m_q8});
    endtask

    // One clock cycle: drive inputs mid-low-phase, check the asynchronous
    // effect of reset right away, then check the result of the rising edge.
    task automatic cycle(input string tag, input logic rst_v, input logic en_v,
                         input logic d1_v, input logic [7:0] d8_v);
        @(negedge clk);
        reset = rst_v;
        en    = en_v;
        d1    = d1_v;
        d8    = d8_v;
        #1;
        if (!rst_v) begin
            m_q1 = RV1;
            m_q8 = RV8;
        end
        check_both({tag, "_pre"});
        @(posedge clk);
        #1;
        if (rst_v) begin
            if (en_v) begin
                m_q1 = d1_v;
                m_q8 = d8_v;
            end
        end else begin
            m_q1 = RV1;
            m_q8 = RV8;
        end
        check_both({tag, "_post"});
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        d1    = 1'b1;
        d8    = 8'h3C;

        // Async reset between edges, before any clock edge can act on it.
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        m_q1 = RV1;
        m_q8 = RV8;
        check_both("async_rst");

        // Held in reset across two rising edges with en=1, d=1.
        cycle("rst_hold0", 1'b0, 1'b1, 1'b1, 8'hFF);
        cycle("rst_hold1", 1'b0, 1'b1, 1'b1, 8'hFF);

        // Release has no immediate effect; first capture on the next edge.
        cycle("release", 1'b1, 1'b1, 1'b1, 8'h3C);

        // Hold for three edges with en=0.
        for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 1'b0, 1'b0, 8'hFF);

        // Enable capture of 0 then 1.
        cycle("cap0", 1'b1, 1'b1, 1'b0, 8'h5A);
        cycle("cap1", 1'b1, 1'b1, 1'b1, 8'h3C);

        // Reset falling exactly at a rising clock edge with en=1, d=1.
        @(posedge clk);
        reset = 1'b0;
        en    = 1'b1;
        d1    = 1'b1;
        d8    = 8'h77;
        #1;
        m_q1 = RV1;
        m_q8 = RV8;
        check_both("coincide");
        cycle("coincide_hold", 1'b0, 1'b1, 1'b1, 8'h77);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 200; i++) begin
            cycle("rand", ($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom),
                  8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
